inst_mem_resp: RTL and testbench
================================

Name: inst_mem_resp

Overview:
Instruction-memory responder at the far end of the PC fetch interface. It accepts the fetch address and chip-enable driven by the PC register and returns the 32-bit instruction after a fixed number of wait states. While an access is outstanding it raises a stall request to the pipeline controller, which freezes the PC. A side load port fills the word array before and during simulation.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait states per access; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce_i  in  1  fetch enable from the PC register; 0 means idle/in reset.
- pc_i  in  32  byte fetch address.
- flush_i  in  1  pipeline flush; aborts any outstanding access.
- inst_o  out  32  instruction returned for pc_i.
- inst_valid_o  out  1  inst_o is valid for the current pc_i.
- addr_err_o  out  1  pc_i is misaligned or out of range.
- stallreq_o  out  1  stall request to the controller; the PC must hold.
- ld_we_i  in  1  load-port write enable.
- ld_addr_i  in  ADDR_W  load-port word address.
- ld_data_i  in  32  load-port write data.

Behaviour:
- Registered state:
  - state: IDLE or WAIT.
  - cnt: wait-state counter, width clog2(WAIT_CYCLES+1), minimum 1 bit.
  - lat_pc[31:0]: address being fetched.
  - resp_pc[31:0], resp_inst[31:0], resp_valid: last completed access.
  - mem: the word array; it is not reset.
- Reset (async): state=IDLE, cnt=0, resp_valid=0, lat_pc=0, resp_pc=0, resp_inst=0. All outputs are 0 while rst=1.
- err = ce_i & ((pc_i[1:0]!=0) | (pc_i[31:ADDR_W+2]!=0)).
- hit = ce_i & resp_valid & (pc_i==resp_pc).
- Combinational outputs:
  - addr_err_o = err.
  - inst_valid_o = hit | err.
  - inst_o = hit ? resp_inst : 0. inst_o is 0 on err.
  - stallreq_o = ce_i & ~err & ~hit & ~flush_i.
- IDLE:
  - If ce_i & ~err & ~hit & ~flush_i: lat_pc<=pc_i, cnt<=WAIT_CYCLES, go to WAIT.
  - Otherwise remain in IDLE.
- WAIT, checked in this priority:
  - flush_i | ~ce_i | (pc_i!=lat_pc): abort and go to IDLE; resp_* is unchanged. A new pc_i is re-accepted in the following cycle.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: resp_inst<=mem[lat_pc[ADDR_W+1:2]], resp_pc<=lat_pc, resp_valid<=1, go to IDLE.
- Latency:
  - A new aligned pc_i presented in cycle k produces hit in cycle k+WAIT_CYCLES+2.
  - stallreq_o is high in cycles k..k+WAIT_CYCLES+1.
  - A repeated pc_i that hits costs 0 cycles.
- Load port:
  - When ld_we_i=1, mem[ld_addr_i]<=ld_data_i at the edge.
  - If ld_addr_i==resp_pc[ADDR_W+1:2], resp_valid<=0 in the same edge, so stale data is never served.
  - If ld_addr_i equals the word being completed in the same edge, the completion reads the old mem value and resp_valid ends at 0. Load invalidation wins over completion.
- ce_i=0: all outputs are 0; any WAIT aborts to IDLE; resp_valid is retained.
- Flush during IDLE: no access starts and stallreq_o=0.
- Reset mid-access: returns immediately to IDLE with resp_valid=0.

Decomposition:
- Shared defines file gets:
  - InstAddrBus and InstBus widths (32).
  - ChipEnable/ChipDisable.
  - Stop/NoStop.
  - IDLE/WAIT state encodings (1 bit).
- One natural sub-module, inst_mem_array:
  - 2^ADDR_W x 32 array.
  - One asynchronous read port and one synchronous write port.
  - No reset.
- The FSM, counter and response registers stay in inst_mem_resp.

Test Plan:
All scenarios use WAIT_CYCLES=2, ADDR_W=10 and mem[0..3] = 0x34010001, 0x34020002, 0x34030003, 0x34040004 loaded via the load port.
1. Basic fetch: ce_i=1, pc_i=0x0 held from cycle 0 -> stallreq_o=1 in cycles 0..3. In cycle 4: inst_o=0x34010001, inst_valid_o=1, stallreq_o=0.
2. Repeat hit: pc_i stays 0x0 after scenario 1 -> stallreq_o=0 every cycle and inst_o=0x34010001. pc_i=0x4 -> a new 4-cycle stall, then inst_o=0x34020002.
3. Redirect mid-WAIT: pc_i=0x8 in cycle 0, changed to 0xC in cycle 2 -> abort. Then inst_o=0x34040004 arrives in cycle 7 and 0x34030003 never appears.
4. Address errors:
   - pc_i=0x6 -> addr_err_o=1, inst_valid_o=1, inst_o=0, stallreq_o=0 in the same cycle.
   - pc_i=0x00001000 -> same response.
5. Load coherency: after hit on 0x0, write ld_addr_i=0, ld_data_i=0xDEADBEEF -> next cycle stallreq_o=1. The refetch returns 0xDEADBEEF.
6. Flush and reset:
   - flush_i=1 for one cycle during WAIT -> stallreq_o=0 that cycle; the fetch restarts.
   - rst=1 asserted mid-WAIT without a clock edge -> outputs 0 immediately.
   - After rst release, a fetch of 0x0 takes the full 4-cycle stall.

Source files
------------

// File: rtl/inst_mem_resp_pkg.sv
// inst_mem_resp_pkg: shared widths, enable/stall encodings and FSM states for the fetch responder
package inst_mem_resp_pkg;
   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;
   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: word array with one async read port and one sync write port, no reset
module inst_mem_array import inst_mem_resp_pkg::*; #(
   parameter int ADDR_W = 10
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [ADDR_W-1:0]  waddr_i,
   input  logic [InstBus-1:0] wdata_i,
   input  logic [ADDR_W-1:0]  raddr_i,
   output logic [InstBus-1:0] rdata_o
);
   logic [InstBus-1:0] mem_q [2**ADDR_W];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction-memory responder returning a word after fixed wait states,
// stalling the PC while a fetch is outstanding and caching the last completed access
module inst_mem_resp import inst_mem_resp_pkg::*; #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce_i,
   input  logic [InstAddrBus-1:0] pc_i,
   input  logic                   flush_i,
   output logic [InstBus-1:0]     inst_o,
   output logic                   inst_valid_o,
   output logic                   addr_err_o,
   output logic                   stallreq_o,
   input  logic                   ld_we_i,
   input  logic [ADDR_W-1:0]      ld_addr_i,
   input  logic [InstBus-1:0]     ld_data_i
);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [InstAddrBus-1:0] lat_pc_q, lat_pc_d, resp_pc_q, resp_pc_d;
   logic [InstBus-1:0]     resp_inst_q, resp_inst_d, rdata;
   logic                   resp_valid_q, resp_valid_d;
   logic                   en, err, hit, start, done;
   inst_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .we_i    (ld_we_i),
      .waddr_i (ld_addr_i),
      .wdata_i (ld_data_i),
      .raddr_i (lat_pc_q[ADDR_W+1:2]),
      .rdata_o (rdata)
   );
   // outputs are forced low while reset is held, even with ce_i still high
   assign en    = (ce_i == ChipEnable) & ~rst;
   assign err   = en & ((pc_i[1:0] != 2'b00) | (pc_i[InstAddrBus-1:ADDR_W+2] != '0));
   assign hit   = en & resp_valid_q & (pc_i == resp_pc_q);
   assign start = en & ~err & ~hit & ~flush_i;
   assign addr_err_o   = err;
   assign inst_valid_o = hit | err;
   assign inst_o       = hit ? resp_inst_q : '0;
   assign stallreq_o   = start ? Stop : NoStop;
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lat_pc_d     = lat_pc_q;
      resp_pc_d    = resp_pc_q;
      resp_inst_d  = resp_inst_q;
      resp_valid_d = resp_valid_q;
      done         = 1'b0;
      if (state_q == IDLE) begin
         if (start) begin
            lat_pc_d = pc_i;
            cnt_d    = CNT_W'(WAIT_CYCLES);
            state_d  = WAIT;
         end
      end else if (flush_i | ~en | (pc_i != lat_pc_q)) begin
         state_d = IDLE;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         done         = 1'b1;
         resp_inst_d  = rdata;
         resp_pc_d    = lat_pc_q;
         resp_valid_d = 1'b1;
         state_d      = IDLE;
      end
      // a load into the cached or completing word invalidates, winning over completion
      if (ld_we_i & ((ld_addr_i == resp_pc_q[ADDR_W+1:2]) | (done & (ld_addr_i == lat_pc_q[ADDR_W+1:2]))))
         resp_valid_d = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         lat_pc_q     <= '0;
         resp_pc_q    <= '0;
         resp_inst_q  <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lat_pc_q     <= lat_pc_d;
         resp_pc_q    <= resp_pc_d;
         resp_inst_q  <= resp_inst_d;
         resp_valid_q <= resp_valid_d;
      end
   end
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed checks of fetch latency, hits, redirects, errors, load coherency, flush and reset
module tb_inst_mem_resp;
   logic        clk = 1'b0;
   logic        rst, ce_i, flush_i, ld_we_i;
   logic [31:0] pc_i, ld_data_i, inst_o;
   logic [9:0]  ld_addr_i;
   logic        inst_valid_o, addr_err_o, stallreq_o;
   int          total = 0, bad = 0;
   logic [31:0] init_words [4] = '{32'h34010001, 32'h34020002, 32'h34030003, 32'h34040004};

   inst_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i), .flush_i(flush_i),
      .inst_o(inst_o), .inst_valid_o(inst_valid_o), .addr_err_o(addr_err_o), .stallreq_o(stallreq_o),
      .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic outs(input string tag, input logic st, input logic v, input logic e, input logic [31:0] ins);
      chk({tag, ".stall"}, {31'b0, stallreq_o}, {31'b0, st});
      chk({tag, ".valid"}, {31'b0, inst_valid_o}, {31'b0, v});
      chk({tag, ".err"}, {31'b0, addr_err_o}, {31'b0, e});
      chk({tag, ".inst"}, inst_o, ins);
   endtask

   task automatic cyc(input string tag, input logic st, input logic v, input logic e, input logic [31:0] ins);
      @(negedge clk);
      outs(tag, st, v, e, ins);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ce_i = 1'b0; pc_i = '0; flush_i = 1'b0;
      ld_we_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      outs("rst", 1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_we_i = 1'b1; ld_addr_i = 10'(i); ld_data_i = init_words[i];
         @(posedge clk);
         #1;
      end
      ld_we_i = 1'b0;
      // basic fetch
      ce_i = 1'b1; pc_i = 32'h0;
      for (int c = 0; c < 4; c++) cyc("s1_stall", 1'b1, 1'b0, 1'b0, 32'h0);
      cyc("s1_hit", 1'b0, 1'b1, 1'b0, 32'h34010001);
      // repeated hit, then next word
      for (int c = 0; c < 3; c++) cyc("s2_rep", 1'b0, 1'b1, 1'b0, 32'h34010001);
      pc_i = 32'h4;
      for (int c = 0; c < 4; c++) cyc("s2_stall", 1'b1, 1'b0, 1'b0, 32'h0);
      cyc("s2_hit", 1'b0, 1'b1, 1'b0, 32'h34020002);
      // redirect mid-WAIT
      pc_i = 32'h8;
      for (int c = 0; c < 2; c++) cyc("s3_stall8", 1'b1, 1'b0, 1'b0, 32'h0);
      pc_i = 32'hC;
      for (int c = 2; c < 7; c++) cyc("s3_stallC", 1'b1, 1'b0, 1'b0, 32'h0);
      cyc("s3_hit", 1'b0, 1'b1, 1'b0, 32'h34040004);
      // address errors
      pc_i = 32'h6;
      cyc("s4_mis", 1'b0, 1'b1, 1'b1, 32'h0);
      pc_i = 32'h00001000;
      cyc("s4_oor", 1'b0, 1'b1, 1'b1, 32'h0);
      // load coherency
      pc_i = 32'h0;
      for (int c = 0; c < 4; c++) cyc("s5_stall", 1'b1, 1'b0, 1'b0, 32'h0);
      ld_we_i = 1'b1; ld_addr_i = 10'd0; ld_data_i = 32'hDEADBEEF;
      cyc("s5_hit", 1'b0, 1'b1, 1'b0, 32'h34010001);
      ld_we_i = 1'b0;
      for (int c = 0; c < 4; c++) cyc("s5_refetch", 1'b1, 1'b0, 1'b0, 32'h0);
      cyc("s5_new", 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
      // flush during WAIT restarts the fetch
      pc_i = 32'h4;
      for (int c = 0; c < 2; c++) cyc("s6_stall", 1'b1, 1'b0, 1'b0, 32'h0);
      flush_i = 1'b1;
      cyc("s6_flush", 1'b0, 1'b0, 1'b0, 32'h0);
      flush_i = 1'b0;
      for (int c = 0; c < 4; c++) cyc("s6_restart", 1'b1, 1'b0, 1'b0, 32'h0);
      cyc("s6_hit", 1'b0, 1'b1, 1'b0, 32'h34020002);
      // reset mid-WAIT, no clock edge between assert and check
      pc_i = 32'h0;
      for (int c = 0; c < 2; c++) cyc("s6_pre_rst", 1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      #1;
      outs("s6_rst", 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) cyc("s6_post_rst", 1'b1, 1'b0, 1'b0, 32'h0);
      cyc("s6_post_hit", 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
      // ce_i low: outputs idle, cached response retained
      ce_i = 1'b0;
      cyc("ce_off", 1'b0, 1'b0, 1'b0, 32'h0);
      ce_i = 1'b1;
      cyc("ce_back", 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
